// File: rtl/dict_id_crossbar.sv
// Routes a serial dictionary-id stream to NUM_BANKS banks by low id bits, tags each id
// with a serial, and closes every transaction with one keep=0/last=1 beat per bank.
// Optional transaction-length statistics: define DICT_ID_CROSSBAR_STATS_EN.
module dict_id_crossbar #(
    parameter int NUM_BANKS    = 4,
    parameter int ID_WIDTH     = 16,
    parameter int SERIAL_WIDTH = 16
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [ID_WIDTH-1:0]                                 in_id,
    input  logic                                                in_last,
    output logic [NUM_BANKS-1:0]                                out_valid,
    input  logic [NUM_BANKS-1:0]                                out_ready,
    output logic [NUM_BANKS*(ID_WIDTH-$clog2(NUM_BANKS))-1:0]   out_id,
    output logic [NUM_BANKS*SERIAL_WIDTH-1:0]                   out_serial,
    output logic [NUM_BANKS-1:0]                                out_keep,
    output logic [NUM_BANKS-1:0]                                out_last
`ifdef DICT_ID_CROSSBAR_STATS_EN
    ,
    output logic                                                stat_valid,
    output logic [SERIAL_WIDTH:0]                               stat_count
`endif
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int LOCAL_W   = ID_WIDTH - BANK_BITS;

    typedef enum logic {ST_ROUTE, ST_TERM} state_t;

    state_t                            state_q, state_d;
    logic [SERIAL_WIDTH-1:0]           serial_q, serial_d;
    logic [NUM_BANKS-1:0]              sent_q, sent_d;
    logic [NUM_BANKS-1:0]              valid_q, valid_d;
    logic [NUM_BANKS*LOCAL_W-1:0]      id_q, id_d;
    logic [NUM_BANKS*SERIAL_WIDTH-1:0] ser_q, ser_d;
    logic [NUM_BANKS-1:0]              keep_q, keep_d;
    logic [NUM_BANKS-1:0]              last_q, last_d;
    logic [NUM_BANKS-1:0]              slot_free;
    logic [BANK_BITS-1:0]              bank_sel;
    logic                              accept;

    always_comb begin
        slot_free = ~valid_q | out_ready;
        bank_sel  = in_id[BANK_BITS-1:0];
        in_ready  = (state_q == ST_ROUTE) && slot_free[bank_sel];
        accept    = in_valid && in_ready;
        state_d   = state_q;
        serial_d  = serial_q;
        sent_d    = sent_q;
        // A drained slot with no reload goes empty; loads below override this.
        valid_d   = valid_q & ~out_ready;
        id_d      = id_q;
        ser_d     = ser_q;
        keep_d    = keep_q;
        last_d    = last_q;
        case (state_q)
            ST_ROUTE: begin
                if (accept) begin
                    valid_d[bank_sel] = 1'b1;
                    id_d[int'(bank_sel)*LOCAL_W +: LOCAL_W]          = in_id[ID_WIDTH-1:BANK_BITS];
                    ser_d[int'(bank_sel)*SERIAL_WIDTH +: SERIAL_WIDTH] = serial_q;
                    keep_d[bank_sel] = 1'b1;
                    last_d[bank_sel] = 1'b0;
                    if (in_last) begin
                        serial_d = '0;
                        state_d  = ST_TERM;
                    end else begin
                        serial_d = serial_q + SERIAL_WIDTH'(1);
                    end
                end
            end
            ST_TERM: begin
                for (int k = 0; k < NUM_BANKS; k++) begin
                    if (!sent_q[k] && slot_free[k]) begin
                        valid_d[k] = 1'b1;
                        id_d[k*LOCAL_W +: LOCAL_W]           = '0;
                        ser_d[k*SERIAL_WIDTH +: SERIAL_WIDTH] = '0;
                        keep_d[k]  = 1'b0;
                        last_d[k]  = 1'b1;
                        sent_d[k]  = 1'b1;
                    end
                end
                if (&sent_d) begin
                    state_d = ST_ROUTE;
                    sent_d  = '0;
                end
            end
            default: state_d = ST_ROUTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_ROUTE;
            serial_q <= '0;
            sent_q   <= '0;
            valid_q  <= '0;
            id_q     <= '0;
            ser_q    <= '0;
            keep_q   <= '0;
            last_q   <= '0;
        end else begin
            state_q  <= state_d;
            serial_q <= serial_d;
            sent_q   <= sent_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            ser_q    <= ser_d;
            keep_q   <= keep_d;
            last_q   <= last_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_id     = id_q;
    assign out_serial = ser_q;
    assign out_keep   = keep_q;
    assign out_last   = last_q;

`ifdef DICT_ID_CROSSBAR_STATS_EN
    logic [SERIAL_WIDTH:0] cnt_q, cnt_d, cnt_inc;
    logic [SERIAL_WIDTH:0] stat_count_q, stat_count_d;
    logic                  stat_valid_q, stat_valid_d;

    always_comb begin
        cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + (SERIAL_WIDTH+1)'(1);
        cnt_d        = cnt_q;
        stat_valid_d = 1'b0;
        stat_count_d = stat_count_q;
        if (accept) begin
            if (in_last) begin
                stat_valid_d = 1'b1;
                stat_count_d = cnt_inc;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            stat_count_q <= '0;
            stat_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            stat_count_q <= stat_count_d;
            stat_valid_q <= stat_valid_d;
        end
    end

    assign stat_valid = stat_valid_q;
    assign stat_count = stat_count_q;
`endif
endmodule

// File: tb/tb_dict_id_crossbar.sv
// Bench for dict_id_crossbar: cycle table for in_ready/out_valid, per-bank scoreboard
// queues for beat contents, plus directed sequences for blocking, serial wrap and reset.
module tb_dict_id_crossbar;
    localparam int NB = 4, IW = 12, SW = 16, LW = 10;

    logic          clk, rst_n, in_valid, in_ready, in_last;
    logic [IW-1:0] in_id;
    logic [NB-1:0] out_valid, out_ready, out_keep, out_last;
    logic [NB*LW-1:0] out_id;
    logic [NB*SW-1:0] out_serial;
`ifdef DICT_ID_CROSSBAR_STATS_EN
    logic          stat_valid;
    logic [SW:0]   stat_count;
`endif

    dict_id_crossbar #(.NUM_BANKS(NB), .ID_WIDTH(IW), .SERIAL_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_id(in_id), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_serial(out_serial), .out_keep(out_keep), .out_last(out_last)
`ifdef DICT_ID_CROSSBAR_STATS_EN
        , .stat_valid(stat_valid), .stat_count(stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [LW-1:0] id;
        logic [SW-1:0] ser;
        logic          keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
        logic          last;
        logic [NB-1:0] rdy;
        logic          er;
        logic [NB-1:0] eov;
    } vec_t;

    int            errors = 0, checks = 0;
    beat_t         sbq[NB][$];
    beat_t         held[NB];
    logic [NB-1:0] hold;
    logic [SW-1:0] mserial;
    int            stat_pulses = 0;
    logic [SW:0]   stat_last = '0;
    vec_t          tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic beat_t cur(input int k);
        beat_t b;
        b.id   = out_id[k*LW +: LW];
        b.ser  = out_serial[k*SW +: SW];
        b.keep = out_keep[k];
        b.last = out_last[k];
        return b;
    endfunction

    // Scoreboard: runs once per cycle at the falling edge, before the next handshake edge.
    task automatic monitor();
        beat_t a, e;
        if (!rst_n) begin
            for (int k = 0; k < NB; k++) sbq[k].delete();
            mserial = '0;
            hold    = '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                a = cur(k);
                if (hold[k]) chk($sformatf("bank%0d_stable", k), 32'({out_valid[k], a}), 32'({1'b1, held[k]}));
                hold[k] = out_valid[k] && !out_ready[k];
                held[k] = a;
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL bank%0d_extra_beat: got id=%0h ser=%0h keep=%0b last=%0b expected none",
                                 k, a.id, a.ser, a.keep, a.last);
                    end else begin
                        e = sbq[k].pop_front();
                        chk($sformatf("bank%0d_beat", k), 32'(a), 32'(e));
                    end
                end
            end
            if (in_valid && in_ready) begin
                sbq[in_id[1:0]].push_back('{id: in_id[IW-1:2], ser: mserial, keep: 1'b1, last: 1'b0});
                if (in_last) begin
                    mserial = '0;
                    for (int k = 0; k < NB; k++) sbq[k].push_back('{id: '0, ser: '0, keep: 1'b0, last: 1'b1});
                end else begin
                    mserial = mserial + 16'd1;
                end
            end
`ifdef DICT_ID_CROSSBAR_STATS_EN
            if (stat_valid) begin
                stat_pulses++;
                stat_last = stat_count;
            end
`endif
        end
    endtask

    task automatic step(input logic v, input logic [IW-1:0] id, input logic last,
                        input logic [NB-1:0] rdy, input logic er, input logic [NB-1:0] eov);
        in_valid = v; in_id = id; in_last = last; out_ready = rdy;
        @(negedge clk);
        monitor();
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(eov));
        @(posedge clk); #1;
    endtask

    initial begin
        int            pulses0;
        logic [IW-1:0] id4;
        rst_n = 1'b0; in_valid = 1'b0; in_id = '0; in_last = 1'b0; out_ready = '0;
        hold = '0; mserial = '0;
        @(posedge clk); #1;
        @(negedge clk);
        monitor();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_keep_last", 32'({out_keep, out_last}), 32'h0);
        chk("rst_id", 32'(out_id), 32'h0);
        chk("rst_serial", 32'(out_serial[31:0]), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // rows 0-6: one id per bank; rows 7-15: three ids to bank0 with a 3-cycle stall
        tbl[0]  = '{1'b1, 12'h005, 1'b0, 4'hF, 1'b1, 4'b0000};
        tbl[1]  = '{1'b1, 12'h00A, 1'b0, 4'hF, 1'b1, 4'b0010};
        tbl[2]  = '{1'b1, 12'h00F, 1'b0, 4'hF, 1'b1, 4'b0100};
        tbl[3]  = '{1'b1, 12'h010, 1'b1, 4'hF, 1'b1, 4'b1000};
        tbl[4]  = '{1'b0, 12'h000, 1'b0, 4'hF, 1'b0, 4'b0001};
        tbl[5]  = '{1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b1111};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 12'h004, 1'b0, 4'hF, 1'b1, 4'b0000};
        tbl[8]  = '{1'b1, 12'h008, 1'b0, 4'hE, 1'b0, 4'b0001};
        tbl[9]  = '{1'b1, 12'h008, 1'b0, 4'hE, 1'b0, 4'b0001};
        tbl[10] = '{1'b1, 12'h008, 1'b0, 4'hE, 1'b0, 4'b0001};
        tbl[11] = '{1'b1, 12'h008, 1'b0, 4'hF, 1'b1, 4'b0001};
        tbl[12] = '{1'b1, 12'h00C, 1'b1, 4'hF, 1'b1, 4'b0001};
        tbl[13] = '{1'b0, 12'h000, 1'b0, 4'hF, 1'b0, 4'b0001};
        tbl[14] = '{1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b1111};
        tbl[15] = '{1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000};
        for (int r = 0; r < 16; r++)
            step(tbl[r].v, tbl[r].id, tbl[r].last, tbl[r].rdy, tbl[r].er, tbl[r].eov);

        // bank2 keeps a previous dummy held, so the next transaction's bank2 terminator must wait
        step(1'b1, 12'h006, 1'b1, 4'hF, 1'b1, 4'b0000);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b0, 4'b0100);
        step(1'b0, 12'h000, 1'b0, 4'hB, 1'b1, 4'b1111);
        step(1'b1, 12'h003, 1'b1, 4'hB, 1'b1, 4'b0100);
        step(1'b0, 12'h000, 1'b0, 4'hB, 1'b0, 4'b1100);
        step(1'b0, 12'h000, 1'b0, 4'hB, 1'b0, 4'b1111);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b0, 4'b0100);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0100);
        step(1'b1, 12'h001, 1'b1, 4'hF, 1'b1, 4'b0000);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b0, 4'b0010);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b1111);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000);

        // 65537 ids alternating banks 0/1: serial wraps on the last one
        pulses0 = stat_pulses;
        for (int i = 0; i < 65537; i++) begin
            id4 = {i[9:0], 1'b0, i[0]};
            in_valid = 1'b1; in_id = id4; in_last = (i == 65536); out_ready = 4'hF;
            @(negedge clk);
            monitor();
            chk("wrap_in_ready", 32'(in_ready), 32'h1);
            if (i == 65536) chk("serial_ffff", 32'(out_serial[SW +: SW]), 32'hFFFF);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_id = '0; in_last = 1'b0;
        @(negedge clk);
        monitor();
        chk("wrap_term_in_ready", 32'(in_ready), 32'h0);
        chk("serial_wrapped", 32'({out_valid[0], out_keep[0], out_serial[0 +: SW]}), 32'h30000);
        @(posedge clk); #1;
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b1111);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000);
`ifdef DICT_ID_CROSSBAR_STATS_EN
        chk("stat_pulses", 32'(stat_pulses - pulses0), 32'd1);
        chk("stat_count", 32'(stat_last), 32'd65537);
`endif

        // reset after 2 of 5 ids with all banks blocked
        step(1'b1, 12'h001, 1'b0, 4'h0, 1'b1, 4'b0000);
        step(1'b1, 12'h002, 1'b0, 4'h0, 1'b1, 4'b0010);
        rst_n = 1'b0;
        step(1'b0, 12'h000, 1'b0, 4'h0, 1'b1, 4'b0110);
        rst_n = 1'b1;
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000);
        step(1'b1, 12'h00E, 1'b1, 4'hF, 1'b1, 4'b0000);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b0, 4'b0100);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b1111);
        step(1'b0, 12'h000, 1'b0, 4'hF, 1'b1, 4'b0000);

        for (int k = 0; k < NB; k++) chk($sformatf("bank%0d_drained", k), 32'(sbq[k].size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
